// File: rtl/prog_delay_pkg.sv
// Shared types, defaults and helpers for the programmable delay line.
package prog_delay_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } dly_state_e;

    localparam int DEF_N_CH      = 2;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_DEPTH = 8;
    localparam int STAGE_W       = DEF_N_CH * DEF_WIDTH + 1;

    function automatic int unsigned clamp_dly(
        input int unsigned cfg,
        input int unsigned max_dly
    );
        return (cfg > max_dly) ? max_dly : cfg;
    endfunction

endpackage

// File: rtl/dly_stage_bank.sv
// Enable-gated shift array of {data, valid} words with a depth-select tap.
module dly_stage_bank
    import prog_delay_pkg::*;
#(
    parameter int SW    = STAGE_W,
    parameter int DEPTH = DEF_MAX_DEPTH,
    parameter int SELW  = $clog2(DEF_MAX_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [SW-1:0]   din,
    input  logic [SELW-1:0] sel,
    output logic [SW-1:0]   tap
);

    logic [SW-1:0] stg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else if (en) begin
            stg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    // sel == 0 is bypass: the live input goes straight through
    always_comb begin
        tap = din;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(sel) == i + 1) begin
                tap = stg[i];
            end
        end
    end

endmodule

// File: rtl/prog_delay_line.sv
// Multi-channel retiming line with programmable depth, stall and bypass.
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MAX_DEPTH  = DEF_MAX_DEPTH,
    localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                  CP,
    input  logic                  CDN,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  en,
    input  logic [DW-1:0]         delay_cfg,
    input  logic                  cfg_load,
    output logic [N_CH*WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  cfg_clamped,
    inout  wire                   VDD,
    inout  wire                   VSS
);

    localparam int SW = N_CH * WIDTH + 1;

    dly_state_e    state_q, state_d;
    logic [DW-1:0] cur_dly_q, cur_dly_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          clamp_q, clamp_d;
    logic [DW-1:0] new_dly;
    logic          over;
    logic [SW-1:0] tap;

    wire [1:0] pwr_unused;
    assign pwr_unused = {VDD, VSS};

    assign new_dly = DW'(clamp_dly(32'(delay_cfg), 32'(MAX_DEPTH)));
    assign over    = int'(delay_cfg) > MAX_DEPTH;

    dly_stage_bank #(
        .SW    (SW),
        .DEPTH (MAX_DEPTH),
        .SELW  (DW)
    ) u_bank (
        .clk   (CP),
        .rst_n (CDN),
        .en    (en),
        .din   ({in_data, in_valid}),
        .sel   (cur_dly_q),
        .tap   (tap)
    );

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_q   <= RUN;
            cur_dly_q <= DW'(1);
            cnt_q     <= '0;
            clamp_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_dly_q <= cur_dly_d;
            cnt_q     <= cnt_d;
            clamp_q   <= clamp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_dly_d = cur_dly_q;
        cnt_d     = cnt_q;
        clamp_d   = 1'b0;
        unique case (state_q)
            RUN: ;
            SETTLE: begin
                if (en) begin
                    if (cnt_q <= DW'(1)) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase
        // A load overrides any settle progress made this cycle
        if (cfg_load) begin
            cur_dly_d = new_dly;
            clamp_d   = over;
            if (new_dly == '0) begin
                state_d = RUN;
                cnt_d   = '0;
            end else if (state_q == SETTLE || new_dly != cur_dly_q) begin
                state_d = SETTLE;
                cnt_d   = new_dly;
            end
        end
    end

    assign busy        = (state_q == SETTLE);
    assign cfg_clamped = clamp_q;
    assign out_data    = tap[SW-1:1];
    assign out_valid   = tap[0] & ~busy;

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench: history-queue model predicts every output cycle.
module tb_prog_delay_line;

    localparam int MAXD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  delay_cfg = '0;
    logic        cfg_load = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        cfg_clamped;
    wire         vdd = 1'b1;
    wire         vss = 1'b0;

    prog_delay_line #(
        .N_CH      (2),
        .WIDTH     (8),
        .MAX_DEPTH (MAXD)
    ) dut (
        .CP          (clk),
        .CDN         (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .en          (en),
        .delay_cfg   (delay_cfg),
        .cfg_load    (cfg_load),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .busy        (busy),
        .cfg_clamped (cfg_clamped),
        .VDD         (vdd),
        .VSS         (vss)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        v;
        logic        b;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Model: history of the last MAXD enabled input words, newest last
    logic [16:0] hist[$];
    int          m_cur;
    int          m_rem;
    bit          m_busy;
    bit          m_clamp;

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < MAXD; i++) hist.push_back('0);
        m_cur   = 1;
        m_rem   = 0;
        m_busy  = 0;
        m_clamp = 0;
    endfunction

    function automatic exp_t predict(input logic [15:0] d, input logic v);
        exp_t e;
        logic [16:0] w;
        if (m_cur == 0) w = {d, v};
        else            w = hist[MAXD - m_cur];
        e.d = w[16:1];
        e.v = w[0] & ~m_busy;
        e.b = m_busy;
        e.c = m_clamp;
        return e;
    endfunction

    function automatic void model_edge(input logic [15:0] d, input logic v,
                                       input logic e, input logic ld,
                                       input logic [3:0] cfg);
        int n;
        if (e) begin
            hist.push_back({d, v});
            void'(hist.pop_front());
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) m_busy = 0;
            end
        end
        m_clamp = 0;
        if (ld) begin
            n = (int'(cfg) > MAXD) ? MAXD : int'(cfg);
            m_clamp = int'(cfg) > MAXD;
            if (n == 0) begin
                m_busy = 0;
            end else if (m_busy || n != m_cur) begin
                m_busy = 1;
                m_rem  = n;
            end
            m_cur = n;
        end
    endfunction

    task automatic cycle(input logic [15:0] d, input logic v, input logic e,
                         input logic ld, input logic [3:0] cfg);
        in_data   = d;
        in_valid  = v;
        en        = e;
        cfg_load  = ld;
        delay_cfg = cfg;
        sb.push_back(predict(d, v));
        @(posedge clk);
        model_edge(d, v, e, ld, cfg);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(16'h0, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic stream(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++)
            cycle(base + 16'(i), 1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (rst_n && sb.size() != 0) begin
            me = sb.pop_front();
            chk("out_data", out_data, me.d);
            chk("out_valid", 16'(out_valid), 16'(me.v));
            chk("busy", 16'(busy), 16'(me.b));
            chk("cfg_clamped", 16'(cfg_clamped), 16'(me.c));
        end
    end

    initial begin
        model_reset();
        in_data   = 16'hFFFF;
        in_valid  = 1'b1;
        en        = 1'b1;
        cfg_load  = 1'b1;
        delay_cfg = 4'd3;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_clamped", 16'(cfg_clamped), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // latency 1 out of reset
        cycle(16'hA155, 1'b1, 1'b1, 1'b0, 4'd0);
        idle(3);

        // reprogram to 5 with an incrementing stream
        cycle(16'h0000, 1'b0, 1'b1, 1'b1, 4'd5);
        stream(16, 16'h0001);
        idle(6);

        // clamp 12 -> 8
        cycle(16'h0000, 1'b0, 1'b1, 1'b1, 4'd12);
        stream(12, 16'h0100);
        idle(9);

        // bypass
        cycle(16'h0000, 1'b0, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 6; i++)
            cycle(16'($urandom), 1'($urandom), 1'b1, 1'b0, 4'd0);

        // stall at depth 4
        cycle(16'h0000, 1'b0, 1'b1, 1'b1, 4'd4);
        stream(6, 16'h0200);
        for (int i = 0; i < 3; i++) cycle(16'hDEAD, 1'b1, 1'b0, 1'b0, 4'd0);
        stream(6, 16'h0206);
        idle(6);

        // overlapping loads: 6 then 2
        cycle(16'h0300, 1'b1, 1'b1, 1'b1, 4'd6);
        stream(2, 16'h0301);
        cycle(16'h0303, 1'b1, 1'b1, 1'b1, 4'd2);
        stream(6, 16'h0304);

        // load accepted while stalled
        cycle(16'h0400, 1'b1, 1'b0, 1'b1, 4'd3);
        stream(6, 16'h0401);

        // reset mid-settle
        cycle(16'h0500, 1'b1, 1'b1, 1'b1, 4'd7);
        stream(2, 16'h0501);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 16'(busy), 16'h0);
        chk("midrst_out_valid", 16'(out_valid), 16'h0);
        chk("midrst_out_data", out_data, 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(16'h0600, 1'b1, 1'b1, 1'b0, 4'd0);
        cycle(16'h0601, 1'b1, 1'b1, 1'b0, 4'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(16'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  4'($urandom_range(0, 15)));
        end
        idle(2);

        @(negedge clk);
        #1;
        chk("sb_drain", 16'(sb.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
- Parametrised successor to the fixed DEL01-style delay insertion used between netlist blocks.
- A clocked, multi-channel retiming line with runtime-programmable depth, valid tracking, stall and bypass.
- Sits between a producer block and consumer block to balance path latency.
- Carries VDD/VSS pass-through pins so it drops into physical netlists alongside the other blocks.

Parameters:
- N_CH, 2, number of independent data channels sharing one valid/enable.
- WIDTH, 8, bits per channel.
- MAX_DEPTH, 8, maximum programmable delay in cycles (>=1).
- DW, $clog2(MAX_DEPTH+1), width of the delay config field (derived, not overridden).

Ports:
- CP  input  1  clock, rising edge.
- CDN  input  1  asynchronous active-low reset.
- in_data  input  N_CH*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH].
- in_valid  input  1  qualifies in_data this cycle.
- en  input  1  shift enable; 0 stalls the whole line.
- delay_cfg  input  DW  requested delay in cycles; sampled only on cfg_load.
- cfg_load  input  1  one-cycle pulse that applies delay_cfg.
- out_data  output  N_CH*WIDTH  delayed data.
- out_valid  output  1  qualifies out_data.
- busy  output  1  high while settling after a depth change.
- cfg_clamped  output  1  one-cycle pulse when a loaded delay_cfg exceeded MAX_DEPTH.
- VDD  inout  1  power, pass-through, no logic.
- VSS  inout  1  ground, pass-through, no logic.

Behaviour:
- Clock and reset: single clock CP. CDN is asynchronous and active-low.
- Reset values:
  - All stage data = 0 and all stage valid bits = 0.
  - Active delay register cur_dly = 1.
  - State = RUN, settle counter = 0.
  - out_data = 0, out_valid = 0, busy = 0, cfg_clamped = 0.
  - Reset mid-settle returns to RUN with cur_dly = 1.
- Storage: MAX_DEPTH stages. Each stage holds N_CH*WIDTH data bits plus 1 valid bit.
- Shifting: when en=1, stage0 <= {in_data, in_valid} and stage[i] <= stage[i-1]. When en=0, all stages hold.
- Output tap:
  - cur_dly >= 1: out_data and out_valid come from stage[cur_dly-1]. Latency is exactly cur_dly enabled cycles.
  - cur_dly = 0 (bypass): out_data = in_data and out_valid = in_valid, combinationally. The stages keep shifting so a later switch sees live history.
- Valid gating: out_valid is forced 0 whenever busy=1. out_data is still driven from the tap.
- Config load (cfg_load=1, sampled in any state):
  - new = min(delay_cfg, MAX_DEPTH).
  - cfg_clamped pulses 1 on the next cycle iff delay_cfg > MAX_DEPTH.
  - cur_dly <= new on the next edge.
- FSM states:
  - RUN: busy=0.
  - SETTLE: busy=1. Settle counter loads new and decrements on each en=1 cycle. On reaching 0 the FSM returns to RUN. This blanks any stale or duplicated samples exposed by the tap move.
- Transitions:
  - RUN + cfg_load with new == cur_dly: stay in RUN, no blanking.
  - RUN + cfg_load with new != cur_dly and new > 0: go to SETTLE.
  - cfg_load with new = 0: go to RUN immediately. Bypass never settles.
  - cfg_load during SETTLE: restart the counter with the latest value. The last load wins.
- en=0 during SETTLE: the counter holds, so settle counts enabled cycles only.
- cfg_load and en=0 in the same cycle: the load is still accepted.

Decomposition:
- Package prog_delay_pkg holds:
  - State enum {RUN, SETTLE}.
  - Function clamp_dly().
  - Localparam for stage width N_CH*WIDTH+1.
- One natural sub-module: dly_stage_bank. It holds the MAX_DEPTH x (N_CH*WIDTH+1) shift array with en, and provides a tap mux indexed by cur_dly.
- The top level holds the FSM, the config register and the power pins.

Test Plan (N_CH=2, WIDTH=8, MAX_DEPTH=8):
- Reset: hold CDN=0 with nonzero inputs -> out_data=0, out_valid=0, busy=0. After release, drive in_data=16'hA155 valid once with en=1 -> output appears exactly 1 cycle later.
- Reprogram: cfg_load with delay_cfg=5, then a stream of incrementing data 0x0001..0x0010 -> busy high for 5 cycles with out_valid=0. After that, out_data equals the input from 5 cycles earlier, with no duplicate or skipped values.
- Clamp: cfg_load with delay_cfg=12 -> cfg_clamped pulses once, cur_dly=8, latency measured at 8.
- Bypass: cfg_load with delay_cfg=0 -> busy never asserts; out_data=in_data in the same cycle.
- Stall: set en=0 for 3 cycles mid-stream at delay 4 -> output frozen, no data lost, total latency 7 cycles.
- Overlap: cfg_load 6, then cfg_load 2 after 2 cycles -> settle restarts, busy clears 2 enabled cycles after the second load.
- Reset mid-settle: assert CDN mid-settle -> busy=0 immediately and cur_dly=1.
